// File: rtl/image_loader.sv
// image_loader: feeds a raw image byte stream into core data memory, holding the
// core in reset while loading, then releasing it and waiting for the core to halt.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   start                  1-cycle pulse; begins a load from IDLE or DONE
//   s_data/s_valid/s_ready byte stream input (valid/ready handshake)
//   mem_addr/mem_din/mem_we  byte-write port into data memory (registered)
//   cpu_rst_n              core reset, active-low; high only while in RUN
//   cpu_halt               core finished (level, sampled in RUN)
//   busy, done             status: LOAD/RUN, DONE
//   byte_count             bytes accepted in the current load
//   checksum               (only with IMAGE_LOADER_CHECKSUM_EN) sum of accepted bytes mod 2**16
//
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN
module image_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned IMG_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [31:0]       mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              cpu_rst_n,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
`ifdef IMAGE_LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] LastCount = CntW'(IMG_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic            we_q, we_d;
    logic            cpu_rst_n_q, cpu_rst_n_d;
    logic            hs;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [15:0]     sum_q, sum_d;
`endif

    assign s_ready = (state_q == StLoad);
    assign hs      = s_valid & s_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = 1'b0;
        cpu_rst_n_d = 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    count_d = '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            StLoad: begin
                if (hs) begin
                    we_d    = 1'b1;
                    // Address uses the pre-increment count, zero-extended, wrapping at 2**32.
                    addr_d  = BASE_ADDR + 32'(count_q);
                    din_d   = s_data;
                    count_d = count_q + 1'b1;
`ifdef IMAGE_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + 16'(s_data);
`endif
                    if (count_q == LastCount) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Release the core only while staying in RUN, so it drops as DONE is entered.
                if (cpu_halt) begin
                    state_d = StDone;
                end else begin
                    cpu_rst_n_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign mem_addr   = addr_q;
    assign mem_din    = din_q;
    assign mem_we     = we_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign busy       = (state_q == StLoad) || (state_q == StRun);
    assign done       = (state_q == StDone);
    assign byte_count = count_q;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    assign checksum   = sum_q;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: a behavioural model predicts each write and the
// status outputs; a negedge monitor pops expected writes and compares.
module tb_image_loader;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned IMG_BYTES = 4;
    localparam logic [31:0] BASE_ADDR = 32'h100;

    localparam int PIdle = 0;
    localparam int PLoad = 1;
    localparam int PRun  = 2;
    localparam int PDone = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [7:0]      s_data = 8'h00;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [31:0]     mem_addr;
    logic [7:0]      mem_din;
    logic            mem_we;
    logic            cpu_rst_n;
    logic            cpu_halt = 1'b0;
    logic            busy;
    logic            done;
    logic [ADDR_W:0] byte_count;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [15:0]     checksum;
`endif

    image_loader #(
        .ADDR_W   (ADDR_W),
        .IMG_BYTES(IMG_BYTES),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .cpu_rst_n (cpu_rst_n),
        .cpu_halt  (cpu_halt),
        .busy      (busy),
        .done      (done),
`ifdef IMAGE_LOADER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, count, running sum, expected write list.
    int          m_phase = PIdle;
    int          m_cnt = 0;
    int          m_sum = 0;
    bit          m_we = 1'b0;
    bit          m_cpu = 1'b0;
    logic [39:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = PIdle;
            m_cnt   = 0;
            m_sum   = 0;
            m_we    = 1'b0;
            m_cpu   = 1'b0;
            exp_q.delete();
        end else begin
            int prev;
            prev = m_phase;
            m_we = 1'b0;
            case (m_phase)
                PIdle, PDone: begin
                    if (start) begin
                        m_phase = PLoad;
                        m_cnt   = 0;
                        m_sum   = 0;
                    end
                end
                PLoad: begin
                    if (s_valid) begin
                        logic [31:0] a;
                        a = BASE_ADDR + 32'(m_cnt);
                        exp_q.push_back({a, s_data});
                        m_we  = 1'b1;
                        m_cnt = m_cnt + 1;
                        m_sum = (m_sum + int'(s_data)) % 65536;
                        if (m_cnt == IMG_BYTES) m_phase = PRun;
                    end
                end
                PRun: if (cpu_halt) m_phase = PDone;
                default: m_phase = PIdle;
            endcase
            m_cpu = (prev == PRun) && (m_phase == PRun);
        end
    end

    // Monitor: sample away from the rising edge.
    always @(negedge clk) begin
        chk("s_ready", 64'(s_ready), 64'(m_phase == PLoad));
        chk("busy", 64'(busy), 64'(m_phase == PLoad || m_phase == PRun));
        chk("done", 64'(done), 64'(m_phase == PDone));
        chk("cpu_rst_n", 64'(cpu_rst_n), 64'(m_cpu));
        chk("byte_count", 64'(byte_count), 64'(m_cnt));
        chk("mem_we", 64'(mem_we), 64'(m_we));
`ifdef IMAGE_LOADER_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(m_sum));
`endif
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                chk("mem_addr", 64'(mem_addr), 64'(e[39:8]));
                chk("mem_din", 64'(mem_din), 64'(e[7:0]));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic halt_core();
        @(negedge clk);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drive bytes until the model reaches RUN; mode 0 = random gaps, 1 = 1,0,0 pattern.
    task automatic feed_image(input int mode);
        int k = 0;
        while (m_phase != PRun && k < 200) begin
            s_valid  = (mode == 1) ? (k % 3 == 0) : ($urandom_range(0, 99) < 60);
            s_data   = 8'($urandom);
            cpu_halt = ($urandom_range(0, 9) == 0);
            k++;
            @(negedge clk);
        end
        s_valid  = 1'b0;
        cpu_halt = 1'b0;
        chk("load_timeout", 64'(m_phase == PRun), 64'd1);
    endtask

    initial begin
        logic [7:0] d4[4];
        d4 = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_din", 64'(mem_din), 64'd0);
        chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed: valid held high, 0x11..0x44, then extra offered bytes must be refused.
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = (i < 4) ? d4[i] : 8'hEE;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("directed_count", 64'(byte_count), 64'(IMG_BYTES));
        repeat (2) @(negedge clk);
        halt_core();

        // Second image rewrites from BASE_ADDR with a gappy stream.
        pulse_start();
        feed_image(1);
        repeat (3) @(negedge clk);
        halt_core();

        // All-0xFF image exercises the checksum accumulation.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 8'hFF;
            @(negedge clk);
        end
        s_valid = 1'b0;
        halt_core();

        // Randomised images with stray start/halt/valid outside their phases.
        for (int img = 0; img < 8; img++) begin
            pulse_start();
            feed_image(0);
            for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
                start = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            start = 1'b0;
            halt_core();
            s_valid = 1'b1;
            repeat (2) @(negedge clk);
            s_valid = 1'b0;
        end

        // Reset mid-load after two bytes; a write pulse is in flight when reset hits.
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_count", 64'(byte_count), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        s_valid = 1'b0;
        chk("post_rst_mem_we", 64'(mem_we), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
